// File: rtl/rv32i_imem_responder.sv
// rv32i_imem_responder: instruction memory with fixed-latency read pipeline and credit-flowed response FIFO.
// Optional RV32I_IMEM_FAULT_CNT_EN adds a saturating fault_count output.
module rv32i_imem_responder #(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0400_0000,
  parameter int          LATENCY     = 2,
  parameter logic [31:0] NOP_WORD    = 32'h0000_0013,
  localparam int         AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [31:0]   req_addr,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [31:0]   rsp_data,
  output logic          rsp_fault,
  input  logic          load_en,
  input  logic [AW-1:0] load_addr,
  input  logic [31:0]   load_data,
  output logic          busy
`ifdef RV32I_IMEM_FAULT_CNT_EN
  , output logic [15:0] fault_count
`endif
);
  localparam int FD = LATENCY + 1;
  localparam int PW = $clog2(FD);
  logic [31:0] mem [DEPTH_WORDS];
  logic [31:0] off, in_d, wd;
  logic [31:0] fd [FD];
  logic [FD-1:0] ff;
  logic [PW-1:0] wp, rp;
  logic [2:0] cnt;
  logic [3:0] inflight;
  logic fault, acc, push, pop, wf, stg_busy;

  // BASE_ADDR is word aligned, so the offset's low bits are the request's alignment bits
  assign off       = req_addr - BASE_ADDR;
  assign fault     = (off[1:0] != 2'b00) || (off[31:2] >= 30'(DEPTH_WORDS));
  assign in_d      = fault ? NOP_WORD : mem[off[AW+1:2]];
  assign req_ready = (inflight + 4'(cnt)) < 4'(FD);
  assign acc       = req_valid & req_ready;
  assign rsp_valid = cnt != 3'd0;
  assign pop       = rsp_valid & rsp_ready;
  assign rsp_data  = rsp_valid ? fd[rp] : '0;
  assign rsp_fault = rsp_valid & ff[rp];
  assign busy      = stg_busy | rsp_valid;

  always_ff @(posedge clk)
    if (load_en) mem[load_addr] <= load_data;

  // The FIFO write is the final latency stage, so only LATENCY-1 registers precede it
  generate
    if (LATENCY == 1) begin : g_direct
      assign push     = acc;
      assign wd       = in_d;
      assign wf       = fault;
      assign inflight = '0;
      assign stg_busy = 1'b0;
    end else begin : g_pipe
      localparam int NS = LATENCY - 1;
      logic [NS-1:0] sv, sf;
      logic [31:0] sd [NS];
      always_ff @(posedge clk or negedge rst)
        if (!rst) sv <= '0;
        else sv <= NS'({sv, acc});
      always_ff @(posedge clk) begin
        sd[0] <= in_d;
        sf <= NS'({sf, fault});
        for (int i = 1; i < NS; i++) sd[i] <= sd[i-1];
      end
      assign push     = sv[NS-1];
      assign wd       = sd[NS-1];
      assign wf       = sf[NS-1];
      assign inflight = 4'($countones(sv));
      assign stg_busy = |sv;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (push) wp <= (wp == PW'(FD - 1)) ? '0 : wp + 1'b1;
      if (pop) rp <= (rp == PW'(FD - 1)) ? '0 : rp + 1'b1;
      cnt <= cnt + 3'(push) - 3'(pop);
    end

  always_ff @(posedge clk)
    if (push) begin
      fd[wp] <= wd;
      ff[wp] <= wf;
    end

  always_ff @(posedge clk)
    if (rst) assert (!(push && cnt == 3'(FD)));

`ifdef RV32I_IMEM_FAULT_CNT_EN
  always_ff @(posedge clk or negedge rst)
    if (!rst) fault_count <= '0;
    else if (pop && rsp_fault && fault_count != 16'hFFFF) fault_count <= fault_count + 1'b1;
`endif
endmodule

// File: tb/tb_rv32i_imem_responder.sv
// tb_rv32i_imem_responder: table-driven and randomized checks against a queue-based reference model.
module tb_rv32i_imem_responder;
  localparam logic [31:0] BASE = 32'h0400_0000;
  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam int LAT = 2;
  logic clk = 0, rst = 0, req_valid = 0, rsp_ready = 0, load_en = 0;
  logic [31:0] req_addr = 0, load_data = 0;
  logic [9:0] load_addr = 0;
  logic req_ready, rsp_valid, rsp_fault, busy;
  logic [31:0] rsp_data;
`ifdef RV32I_IMEM_FAULT_CNT_EN
  logic [15:0] fault_count;
`endif

  rv32i_imem_responder dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_fault(rsp_fault),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data), .busy(busy)
`ifdef RV32I_IMEM_FAULT_CNT_EN
    , .fault_count(fault_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {logic [31:0] d; logic f; int t;} rsp_t;
  typedef struct {logic [31:0] addr; logic [31:0] d; logic f;} vec_t;
  int vecs = 0, errs = 0, cyc = 0, acc_cnt = 0, fcnt = 0;
  logic [31:0] mdl [1024];
  rsp_t q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic rsp_t expect_of(input logic [31:0] a);
    logic [31:0] w;
    rsp_t r;
    w = (a - BASE) >> 2;
    r.f = (a % 4 != 0) || (w >= 1024);
    r.d = r.f ? NOP : mdl[w[9:0]];
    r.t = cyc;
    return r;
  endfunction

  // Check outputs against the model, then advance one clock and update the model
  task automatic step();
    bit ev, acc, pop;
    ev = 0;
    if (q.size() != 0) ev = (q[0].t + LAT <= cyc);
    chk("req_ready", 32'(req_ready), 32'(q.size() < LAT + 1));
    chk("rsp_valid", 32'(rsp_valid), 32'(ev));
    chk("busy", 32'(busy), 32'(q.size() != 0));
    if (ev) begin
      chk("rsp_data", rsp_data, q[0].d);
      chk("rsp_fault", 32'(rsp_fault), 32'(q[0].f));
    end
`ifdef RV32I_IMEM_FAULT_CNT_EN
    chk("fault_count", 32'(fault_count), 32'(fcnt));
`endif
    @(posedge clk);
    acc = req_valid && (q.size() < LAT + 1);
    pop = ev && rsp_ready;
    if (pop) begin
      if (q[0].f && fcnt < 65535) fcnt++;
      void'(q.pop_front());
    end
    if (acc) begin
      q.push_back(expect_of(req_addr));
      acc_cnt++;
    end
    if (load_en) mdl[load_addr] = load_data;
    cyc++;
    @(negedge clk);
  endtask

  task automatic fetch_one(input logic [31:0] a, input string name, input logic [31:0] d, input logic f);
    req_valid = 1; req_addr = a; rsp_ready = 1;
    step();
    req_valid = 0;
    step();
    chk({name, "_valid"}, 32'(rsp_valid), 32'd1);
    chk({name, "_data"}, rsp_data, d);
    chk({name, "_fault"}, 32'(rsp_fault), 32'(f));
    step();
  endtask

  vec_t tbl[5];
  logic [31:0] old_w;
  int a0;

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_fault", 32'(rsp_fault), 0);
    chk("rst_busy", 32'(busy), 0);
    rst = 1;
    load_en = 1;
    for (int i = 0; i < 1024; i++) begin
      load_addr = 10'(i);
      load_data = (i == 0) ? 32'h0050_0093 : $urandom;
      step();
    end
    load_en = 0;
    fetch_one(BASE, "first_fetch", 32'h0050_0093, 0);
    rsp_ready = 1;
    for (int i = 0; i < 8; i++) begin
      req_valid = 1; req_addr = BASE + 32'(4 * i);
      chk("b2b_req_ready", 32'(req_ready), 1);
      step();
    end
    req_valid = 0;
    repeat (2) step();
    chk("b2b_drained", 32'(busy), 0);
    rsp_ready = 0; req_valid = 1; req_addr = BASE + 32'h20; a0 = acc_cnt;
    repeat (5) step();
    chk("stall_accepts", 32'(acc_cnt - a0), 3);
    chk("stall_req_ready", 32'(req_ready), 0);
    req_valid = 0; rsp_ready = 1;
    repeat (3) step();
    chk("stall_drained", 32'(busy), 0);
    tbl[0] = '{BASE + 32'h2, NOP, 1'b1};
    tbl[1] = '{BASE + 32'h1000, NOP, 1'b1};
    tbl[2] = '{32'h03FF_FFFC, NOP, 1'b1};
    tbl[3] = '{BASE + 32'hFFC, mdl[1023], 1'b0};
    tbl[4] = '{BASE + 32'h8, mdl[2], 1'b0};
    foreach (tbl[i]) fetch_one(tbl[i].addr, "tbl", tbl[i].d, tbl[i].f);
    old_w = mdl[5];
    load_en = 1; load_addr = 10'd5; load_data = ~old_w;
    req_valid = 1; req_addr = BASE + 32'h14;
    step();
    load_en = 0; req_valid = 0;
    step();
    chk("rbw_old", rsp_data, old_w);
    step();
    fetch_one(BASE + 32'h14, "rbw_new", ~old_w, 0);
    rsp_ready = 0; req_valid = 1; req_addr = BASE;
    repeat (3) step();
    req_valid = 0;
    rst = 0;
    #1;
    chk("midrst_rsp_valid", 32'(rsp_valid), 0);
    chk("midrst_busy", 32'(busy), 0);
    q.delete();
    fcnt = 0;
    @(negedge clk);
    rst = 1; rsp_ready = 1;
    repeat (3) step();
    fetch_one(BASE, "mem_kept", 32'h0050_0093, 0);
    for (int n = 0; n < 600; n++) begin
      int r;
      r = $urandom_range(0, 9);
      req_valid = ($urandom_range(0, 3) != 0);
      rsp_ready = ($urandom_range(0, 2) != 0);
      load_en = ($urandom_range(0, 4) == 0);
      load_addr = 10'($urandom);
      load_data = $urandom;
      req_addr = (r < 6) ? BASE + 32'(4 * $urandom_range(0, 1023)) :
                 (r == 6) ? BASE + 32'(4 * $urandom_range(0, 1023)) + 32'($urandom_range(1, 3)) :
                 (r == 7) ? BASE + 32'h1000 + 32'(4 * $urandom_range(0, 4095)) :
                 (r == 8) ? BASE - 32'(4 * $urandom_range(1, 4096)) : $urandom;
      step();
    end
    req_valid = 0; load_en = 0; rsp_ready = 1;
    repeat (6) step();
    chk("final_idle", 32'(busy), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
